// File: rtl/stage_if_if.sv
// stage_if_if: byte-wide memory read port between the fetch stage and the arbiter
interface stage_if_if;
   logic        mem_rd_o;
   logic [31:0] mem_addr_o;
   logic        mem_gnt_i;
   logic [7:0]  mem_din_i;
   modport master (output mem_rd_o, mem_addr_o, input mem_gnt_i, mem_din_i);
   modport slave  (input mem_rd_o, mem_addr_o, output mem_gnt_i, mem_din_i);
endinterface

// File: rtl/stage_if.sv
// stage_if: instruction fetch stage, assembles each 32-bit word from four byte reads
module stage_if #(
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              stall_i,
   input  logic              branch_enable_i,
   input  logic [31:0]       branch_addr_i,
   stage_if_if.master        mem,
   output logic              inst_valid_o,
   output logic [31:0]       inst_o,
   output logic [31:0]       pc_o
);
   typedef enum logic {FETCH, VALID} state_t;
   state_t      state;
   logic [31:0] pc, inst;
   logic [2:0]  issue_cnt;
   logic [1:0]  recv_cnt;
   logic        pending, req, redirect;
   always_comb begin
      req            = !rst && rdy && state == FETCH && !issue_cnt[2];
      redirect       = branch_enable_i && !stall_i;
      mem.mem_rd_o   = req;
      mem.mem_addr_o = rst ? 32'h0 : pc + {29'h0, issue_cnt};
      inst_valid_o   = !rst && state == VALID && !branch_enable_i;
      inst_o         = inst_valid_o ? inst : 32'h0;
      pc_o           = inst_valid_o ? pc : 32'h0;
   end
   // bytes shift in from the top so byte0 ends up in [7:0] after four captures
   always_ff @(posedge clk) begin
      if (rst) begin
         pc        <= RESET_PC;
         state     <= FETCH;
         issue_cnt <= '0;
         recv_cnt  <= '0;
         pending   <= 1'b0;
         inst      <= '0;
      end else if (rdy) begin
         if (redirect) begin
            pc        <= branch_addr_i & ~32'h3;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            pending   <= 1'b0;
            state     <= FETCH;
         end else if (state == FETCH) begin
            pending <= req && mem.mem_gnt_i;
            if (req && mem.mem_gnt_i)
               issue_cnt <= issue_cnt + 3'd1;
            if (pending) begin
               inst     <= {mem.mem_din_i, inst[31:8]};
               recv_cnt <= recv_cnt + 2'd1;
               if (recv_cnt == 2'd3) begin
                  state     <= VALID;
                  issue_cnt <= '0;
               end
            end
         end else if (!stall_i) begin
            pc    <= pc + 32'd4;
            state <= FETCH;
         end
      end
   end
endmodule
